classifier_arbiter: RTL and testbench

CLASSIFIER_ARBITER -- requirements
Module: classifier_arbiter

---
 rtl/classifier_arbiter.sv | 132 +++++++++++++
 tb/tb_classifier_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/classifier_arbiter.sv
// Round-robin arbiter that time-shares one digit classifier among NUM_REQ requesters.
// Define CLS_ARB_WATCHDOG_EN to enable the WAIT-state timeout (resp_err / digit 4'hF).
module classifier_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*196-1:0] req_image,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     resp_valid,
  output logic [3:0]             resp_digit,
  output logic                   resp_err,
  output logic                   cls_start,
  output logic [195:0]           cls_image,
  input  logic [3:0]             cls_digit,
  input  logic                   cls_valid,
  output logic                   busy,
  output logic [2:0]             grant_id
);
  localparam int IMG_W = 196;
  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                          state;
  logic [IDX_W-1:0]                rr_ptr;
  logic [IDX_W-1:0]                owner;
  logic                            cls_valid_q;
  logic                            cls_edge;
  logic                            gnt_found;
  logic [IDX_W-1:0]                gnt_idx;
  logic [NUM_REQ-1:0][IMG_W-1:0]   img_arr;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_img
    assign img_arr[g] = req_image[g*IMG_W +: IMG_W];
  end

  // First requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin : arb
    int               idx;
    logic [IDX_W-1:0] cand;
    idx       = 0;
    cand      = '0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx  = (int'(rr_ptr) + k) % NUM_REQ;
      cand = IDX_W'(idx);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // History resets high so a valid already asserted at reset release is not an edge.
  assign cls_edge = cls_valid & ~cls_valid_q;
  assign busy     = (state != S_IDLE);
  assign grant_id = 3'(owner);

`ifdef CLS_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;
`else
  assign resp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      owner       <= '0;
      req_ready   <= '0;
      resp_valid  <= '0;
      cls_start   <= 1'b0;
      resp_digit  <= '0;
      cls_image   <= '0;
      cls_valid_q <= 1'b1;
`ifdef CLS_ARB_WATCHDOG_EN
      resp_err    <= 1'b0;
      wd_cnt      <= '0;
`endif
    end else begin
      cls_valid_q <= cls_valid;
      req_ready   <= '0;
      resp_valid  <= '0;
      cls_start   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (gnt_found) begin
            cls_image          <= img_arr[gnt_idx];
            owner              <= gnt_idx;
            req_ready[gnt_idx] <= 1'b1;
            state              <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cls_start <= 1'b1;
`ifdef CLS_ARB_WATCHDOG_EN
          wd_cnt    <= '0;
`endif
          state     <= S_WAIT;
        end
        S_WAIT: begin
          // A result wins over a timeout landing in the same cycle.
          if (cls_edge) begin
            resp_digit <= cls_digit;
            state      <= S_RESP;
`ifdef CLS_ARB_WATCHDOG_EN
            resp_err   <= 1'b0;
          end else if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
            resp_digit <= 4'hF;
            resp_err   <= 1'b1;
            state      <= S_RESP;
          end else begin
            wd_cnt     <= wd_cnt + 1'b1;
`endif
          end
        end
        S_RESP: begin
          resp_valid[owner] <= 1'b1;
          rr_ptr            <= (int'(owner) == NUM_REQ - 1) ? '0 : owner + 1'b1;
          state             <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_classifier_arbiter.sv
// Randomized bench for classifier_arbiter: behavioural classifier responder plus a
// round-robin reference (pointer arithmetic) predicting grants, digits and latency.
module tb_classifier_arbiter;
  localparam int N  = 4;
  localparam int TO = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [N*196-1:0] req_image = '0;
  logic [N-1:0]     req_ready, resp_valid;
  logic [3:0]       resp_digit;
  logic             resp_err, cls_start, busy;
  logic [195:0]     cls_image;
  logic [3:0]       cls_digit;
  logic             cls_valid;
  logic [2:0]       grant_id;

  classifier_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_image(req_image),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_digit(resp_digit),
    .resp_err(resp_err), .cls_start(cls_start), .cls_image(cls_image),
    .cls_digit(cls_digit), .cls_valid(cls_valid), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int           n_pass = 0;
  int           n_chk  = 0;
  int           exp_ptr = 0;
  logic [195:0] imgs [N];
  logic [N-1:0] one = 1;

  // Classifier responder: valid drops when a start is taken, rises cm_lat cycles later.
  bit           cm_auto = 1'b1;
  bit           cm_hang = 1'b0;
  bit           cm_mv   = 1'b0;
  logic [3:0]   cm_md   = '0;
  int           cm_lat  = 2;
  int           cm_cnt  = 0;
  logic [195:0] cm_img  = '0;

  function automatic logic [3:0] digit_of(logic [195:0] img);
    return 4'($countones(img) % 10);
  endfunction

  function automatic int ref_grant(logic [N-1:0] rv, int ptr);
    for (int k = 0; k < N; k++)
      if (rv[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  initial begin
    logic         s;
    logic [195:0] img;
    cls_valid = 1'b0;
    cls_digit = '0;
    forever begin
      @(posedge clk);
      s   = cls_start;
      img = cls_image;
      #1;
      if (!cm_auto) begin
        cls_valid = cm_mv;
        cls_digit = cm_md;
      end else if (s) begin
        cls_valid = 1'b0;
        cm_img    = img;
        cm_cnt    = cm_hang ? 0 : cm_lat - 1;
      end else if (cm_cnt > 0) begin
        cm_cnt--;
        if (cm_cnt == 0) begin
          cls_valid = 1'b1;
          cls_digit = digit_of(cm_img);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_images();
    for (int i = 0; i < N; i++) begin
      for (int w = 0; w < 6; w++) imgs[i][w*32 +: 32] = $urandom;
      imgs[i][195:192] = 4'($urandom);
      req_image[i*196 +: 196] = imgs[i];
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    tick();
    rst_n = 1'b1;
    tick();
    exp_ptr = 0;
  endtask

  // Drives one job to completion and reports what the DUT did; callers compare.
  task automatic run_job(input bit drop, input bit churn, input int lim,
                         output logic [N-1:0] rdy, output int t_rdy, output int n_rdy,
                         output int n_start, output logic [N-1:0] rsp,
                         output logic [3:0] dig, output logic err, output int lat,
                         output bit ok);
    int          cyc;
    bit          seen;
    logic [31:0] r;
    cyc = 0; seen = 0; rdy = '0; t_rdy = 0; n_rdy = 0; n_start = 0;
    rsp = '0; dig = '0; err = 1'b0; lat = 0; ok = 0;
    while (cyc < lim && !ok) begin
      tick();
      cyc++;
      if (cls_start) n_start++;
      if (req_ready != '0) begin
        n_rdy++;
        if (!seen) begin
          seen = 1; rdy = req_ready; t_rdy = cyc;
          if (drop) req_valid = req_valid & ~req_ready;
        end
      end
      if (seen && resp_valid != '0) begin
        rsp = resp_valid; dig = resp_digit; err = resp_err; lat = cyc - t_rdy; ok = 1;
      end else if (seen && churn) begin
        r = $urandom;
        req_valid = r[N-1:0];
      end
    end
  endtask

  logic [N-1:0] rdy, rsp;
  logic [3:0]   dig;
  logic         err;
  int           t_rdy, n_rdy, n_start, lat;
  bit           ok;

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '0; set_images();
    repeat (2) tick();
    n_chk++; if ({req_ready, resp_valid, cls_start, busy, resp_err} !== '0) $display("FAIL reset_ctl got=%b exp=0", {req_ready, resp_valid, cls_start, busy, resp_err}); else n_pass++;
    n_chk++; if (grant_id !== 3'd0) $display("FAIL reset_grant got=%0d exp=0", grant_id); else n_pass++;
    n_chk++; if (resp_digit !== 4'd0) $display("FAIL reset_digit got=%0d exp=0", resp_digit); else n_pass++;
    n_chk++; if (cls_image !== '0) $display("FAIL reset_image got=%h exp=0", cls_image); else n_pass++;
    rst_n = 1'b1;
    repeat (2) tick();
    n_chk++; if ({busy, req_ready} !== '0) $display("FAIL reset_idle got=%b exp=0", {busy, req_ready}); else n_pass++;
    exp_ptr = 0;
  endtask

  task automatic test_single();
    imgs[2] = 196'h7F;
    req_image[2*196 +: 196] = imgs[2];
    cm_lat = 3;
    req_valid = 4'b0100;
    run_job(1, 0, 60, rdy, t_rdy, n_rdy, n_start, rsp, dig, err, lat, ok);
    n_chk++; if (!ok) $display("FAIL single_timeout got=no_resp exp=resp"); else n_pass++;
    n_chk++; if (rdy !== 4'b0100 || n_rdy != 1) $display("FAIL single_ready got=%b x%0d exp=0100 x1", rdy, n_rdy); else n_pass++;
    n_chk++; if (n_start != 1) $display("FAIL single_start got=%0d exp=1", n_start); else n_pass++;
    n_chk++; if (rsp !== 4'b0100 || dig !== 4'd7 || err !== 1'b0) $display("FAIL single_resp got=%b/%0d/%b exp=0100/7/0", rsp, dig, err); else n_pass++;
    n_chk++; if (lat != 6) $display("FAIL single_latency got=%0d exp=6", lat); else n_pass++;
    exp_ptr = 3;
  endtask

  task automatic test_rotation();
    do_reset();
    set_images();
    req_valid = '1;
    for (int k = 0; k < N; k++) begin
      cm_lat = 2 + k;
      run_job(0, 0, 60, rdy, t_rdy, n_rdy, n_start, rsp, dig, err, lat, ok);
      n_chk++; if (rdy !== (one << k) || grant_id !== 3'(k)) $display("FAIL rot_grant%0d got=%b/%0d exp=%b/%0d", k, rdy, grant_id, one << k, k); else n_pass++;
      n_chk++; if (rsp !== (one << k) || dig !== digit_of(imgs[k]) || lat != cm_lat + 3) $display("FAIL rot_resp%0d got=%b/%0d/%0d exp=%b/%0d/%0d", k, rsp, dig, lat, one << k, digit_of(imgs[k]), cm_lat + 3); else n_pass++;
    end
    req_valid = '0;
    exp_ptr = 0;
  endtask

  task automatic test_random();
    logic [N-1:0] rv;
    logic [31:0]  r;
    int           g;
    for (int it = 0; it < 24; it++) begin
      r  = $urandom;
      rv = r[N-1:0];
      if (rv == '0) rv = one << $urandom_range(0, N - 1);
      g = ref_grant(rv, exp_ptr);
      set_images();
      cm_lat = $urandom_range(2, 6);
      req_valid = rv;
      run_job(1, 1, 80, rdy, t_rdy, n_rdy, n_start, rsp, dig, err, lat, ok);
      n_chk++; if (!ok) $display("FAIL rnd%0d_timeout got=no_resp exp=resp", it); else n_pass++;
      n_chk++; if (rdy !== (one << g) || grant_id !== 3'(g) || t_rdy != 1) $display("FAIL rnd%0d_grant got=%b/%0d@%0d exp=%b/%0d@1", it, rdy, grant_id, t_rdy, one << g, g); else n_pass++;
      n_chk++; if (n_rdy != 1 || n_start != 1) $display("FAIL rnd%0d_pulses got=%0d/%0d exp=1/1", it, n_rdy, n_start); else n_pass++;
      n_chk++; if (rsp !== (one << g) || dig !== digit_of(imgs[g]) || err !== 1'b0) $display("FAIL rnd%0d_resp got=%b/%0d/%b exp=%b/%0d/0", it, rsp, dig, err, one << g, digit_of(imgs[g])); else n_pass++;
      n_chk++; if (lat != cm_lat + 3) $display("FAIL rnd%0d_latency got=%0d exp=%0d", it, lat, cm_lat + 3); else n_pass++;
      n_chk++; if (cls_image !== imgs[g]) $display("FAIL rnd%0d_image got=%h exp=%h", it, cls_image, imgs[g]); else n_pass++;
      exp_ptr = (g + 1) % N;
    end
    req_valid = '0;
  endtask

  task automatic test_stale();
    int g, waited, early;
    bit seen;
    cm_mv = 1'b1; cm_md = 4'd3; cm_auto = 1'b0;
    tick();
    set_images();
    g = ref_grant(4'b0001, exp_ptr);
    req_valid = 4'b0001;
    seen = 0;
    for (int i = 0; i < 5 && !seen; i++) begin
      tick();
      if (req_ready != '0) seen = 1;
    end
    req_valid = '0;
    n_chk++; if (!seen) $display("FAIL stale_grant got=no_ready exp=ready"); else n_pass++;
    early = 0;
    repeat (8) begin
      tick();
      if (resp_valid != '0) early++;
    end
    n_chk++; if (early != 0 || busy !== 1'b1) $display("FAIL stale_held got=%0d/%b exp=0/1", early, busy); else n_pass++;
    cm_mv = 1'b0;
    tick();
    cm_mv = 1'b1;
    waited = 0;
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      waited++;
      if (resp_valid != '0) seen = 1;
    end
    n_chk++; if (!seen || waited != 3) $display("FAIL stale_edge got=%0d exp=3", waited); else n_pass++;
    n_chk++; if (resp_valid !== (one << g) || resp_digit !== 4'd3) $display("FAIL stale_resp got=%b/%0d exp=%b/3", resp_valid, resp_digit, one << g); else n_pass++;
    exp_ptr = (g + 1) % N;
    cm_auto = 1'b1;
  endtask

  task automatic test_reset_mid();
    int  seen_rsp;
    bit  seen;
    do_reset();
    cm_hang = 1'b1;
    set_images();
    req_valid = 4'b0100;
    seen = 0;
    for (int i = 0; i < 5 && !seen; i++) begin
      tick();
      if (req_ready != '0) seen = 1;
    end
    req_valid = '0;
    repeat (3) tick();
    n_chk++; if (!seen || busy !== 1'b1 || grant_id !== 3'd2) $display("FAIL mid_wait got=%b/%0d exp=1/2", busy, grant_id); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_chk++; if ({req_ready, resp_valid, cls_start, busy, resp_err} !== '0 || grant_id !== 3'd0) $display("FAIL mid_async got=%b/%0d exp=0/0", {req_ready, resp_valid, cls_start, busy, resp_err}, grant_id); else n_pass++;
    n_chk++; if (resp_digit !== 4'd0 || cls_image !== '0) $display("FAIL mid_data got=%0d/%h exp=0/0", resp_digit, cls_image); else n_pass++;
    seen_rsp = 0;
    repeat (4) begin
      tick();
      if (resp_valid != '0) seen_rsp++;
    end
    rst_n = 1'b1;
    cm_hang = 1'b0;
    tick();
    if (resp_valid != '0) seen_rsp++;
    n_chk++; if (seen_rsp != 0) $display("FAIL mid_noresp got=%0d exp=0", seen_rsp); else n_pass++;
    cm_lat = 2;
    req_valid = 4'b1100;
    run_job(1, 0, 60, rdy, t_rdy, n_rdy, n_start, rsp, dig, err, lat, ok);
    n_chk++; if (rdy !== 4'b0100 || grant_id !== 3'd2) $display("FAIL mid_regrant got=%b/%0d exp=0100/2", rdy, grant_id); else n_pass++;
    n_chk++; if (!ok || rsp !== 4'b0100 || dig !== digit_of(imgs[2])) $display("FAIL mid_resp got=%b/%0d exp=0100/%0d", rsp, dig, digit_of(imgs[2])); else n_pass++;
    req_valid = '0;
    exp_ptr = 3;
  endtask

`ifdef CLS_ARB_WATCHDOG_EN
  task automatic test_watchdog();
    int g;
    cm_hang = 1'b1;
    set_images();
    g = ref_grant(4'b0010, exp_ptr);
    req_valid = 4'b0010;
    run_job(1, 0, 80, rdy, t_rdy, n_rdy, n_start, rsp, dig, err, lat, ok);
    n_chk++; if (!ok || rsp !== (one << g) || lat != TO + 2) $display("FAIL wd_timeout got=%b@%0d exp=%b@%0d", rsp, lat, one << g, TO + 2); else n_pass++;
    n_chk++; if (dig !== 4'hF || err !== 1'b1) $display("FAIL wd_err got=%h/%b exp=f/1", dig, err); else n_pass++;
    exp_ptr = (g + 1) % N;
    cm_hang = 1'b0;
    cm_lat = 4;
    g = ref_grant('1, exp_ptr);
    req_valid = '1;
    run_job(1, 0, 80, rdy, t_rdy, n_rdy, n_start, rsp, dig, err, lat, ok);
    req_valid = '0;
    n_chk++; if (!ok || rdy !== (one << g) || dig !== digit_of(imgs[g]) || err !== 1'b0 || lat != 7) $display("FAIL wd_next got=%b/%0d/%b@%0d exp=%b/%0d/0@7", rdy, dig, err, lat, one << g, digit_of(imgs[g])); else n_pass++;
  endtask
`else
  task automatic test_no_watchdog();
    cm_hang = 1'b1;
    set_images();
    req_valid = 4'b0010;
    run_job(1, 0, 50, rdy, t_rdy, n_rdy, n_start, rsp, dig, err, lat, ok);
    n_chk++; if (ok || busy !== 1'b1 || n_rdy != 1) $display("FAIL nowd_hold got=%b/%b/%0d exp=0/1/1", ok, busy, n_rdy); else n_pass++;
    n_chk++; if (resp_err !== 1'b0) $display("FAIL nowd_err got=%b exp=0", resp_err); else n_pass++;
    cm_hang = 1'b0;
    do_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_random();
    test_stale();
    test_reset_mid();
`ifdef CLS_ARB_WATCHDOG_EN
    test_watchdog();
`else
    test_no_watchdog();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
